// File: rtl/ycbcr_block_pkg.sv
// Shared constants for the YCbCr 8x8 block buffer.
// Component codes match the out_comp encoding seen by the DCT stage.
package ycbcr_block_pkg;

    localparam int BLOCK_DIM          = 8;
    localparam int BLOCK_PIXELS       = 64;
    localparam int LEVEL_SHIFT        = 128;
    localparam int ROWS_PER_BLOCK_OUT = 24;

    typedef enum logic [1:0] {
        COMP_Y  = 2'd0,
        COMP_CB = 2'd1,
        COMP_CR = 2'd2
    } comp_e;

endpackage

// File: rtl/ycbcr_round_shift.sv
// Round half up, clamp to 0..255, then level shift to signed -128..127.
module ycbcr_round_shift
    import ycbcr_block_pkg::*;
#(
    parameter int SCALE              = 16,
    parameter int FIXED_POINT_LENGTH = 32
) (
    input  logic [FIXED_POINT_LENGTH-1:0] i_word,
    output logic [7:0]                    o_sample
);

    localparam int FPL = FIXED_POINT_LENGTH;
    localparam logic signed [FPL:0] HALF = (FPL+1)'(1) << (SCALE - 1);

    logic signed [FPL:0] w_sum;
    logic signed [FPL:0] w_t;
    logic [7:0]          w_clamped;

    // One guard bit keeps the rounding add from overflowing.
    assign w_sum = $signed({i_word[FPL-1], i_word}) + HALF;
    assign w_t   = w_sum >>> SCALE;

    always_comb begin
        w_clamped = w_t[7:0];
        if (w_t[FPL])
            w_clamped = 8'd0;
        else if (|w_t[FPL-1:8])
            w_clamped = 8'd255;
    end

    assign o_sample = w_clamped - 8'(LEVEL_SHIFT);

endmodule

// File: rtl/ycbcr_block_buffer.sv
// Ping-pong 8x8 block buffer feeding row beats (Y, Cb, Cr) to the DCT.
module ycbcr_block_buffer
    import ycbcr_block_pkg::*;
#(
    parameter int SCALE              = 16,
    parameter int FIXED_POINT_LENGTH = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FIXED_POINT_LENGTH-1:0] in_Y,
    input  logic [FIXED_POINT_LENGTH-1:0] in_Cb,
    input  logic [FIXED_POINT_LENGTH-1:0] in_Cr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [63:0]                   out_data,
    output logic [1:0]                    out_comp,
    output logic [2:0]                    out_row,
    output logic                          out_last
);

    logic [23:0] r_mem [0:2*BLOCK_PIXELS-1];
    logic [1:0]  r_full;
    logic        r_wr_bank;
    logic [5:0]  r_wr_idx;
    logic        r_rd_bank;
    logic [2:0]  r_rd_row;
    comp_e       r_rd_comp;

    logic [7:0]  w_y;
    logic [7:0]  w_cb;
    logic [7:0]  w_cr;
    logic        w_in_fire;
    logic        w_out_fire;
    logic        w_wr_done;
    logic        w_rd_last;
    logic        w_rd_done;
    logic [1:0]  w_full_nxt;
    comp_e       w_comp_nxt;
    logic [63:0] w_row;

    ycbcr_round_shift #(
        .SCALE(SCALE), .FIXED_POINT_LENGTH(FIXED_POINT_LENGTH)
    ) u_rs_y (.i_word(in_Y), .o_sample(w_y));

    ycbcr_round_shift #(
        .SCALE(SCALE), .FIXED_POINT_LENGTH(FIXED_POINT_LENGTH)
    ) u_rs_cb (.i_word(in_Cb), .o_sample(w_cb));

    ycbcr_round_shift #(
        .SCALE(SCALE), .FIXED_POINT_LENGTH(FIXED_POINT_LENGTH)
    ) u_rs_cr (.i_word(in_Cr), .o_sample(w_cr));

    assign in_ready   = !r_full[r_wr_bank];
    assign out_valid  = r_full[r_rd_bank];
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_wr_done  = w_in_fire && (r_wr_idx == 6'(BLOCK_PIXELS - 1));
    assign w_rd_last  = (r_rd_comp == COMP_CR) &&
                        (r_rd_row == 3'(BLOCK_DIM - 1));
    assign w_rd_done  = w_out_fire && w_rd_last;

    // Write and read completion always target different banks.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_done)
            w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_done)
            w_full_nxt[r_rd_bank] = 1'b0;
    end

    always_comb begin
        case (r_rd_comp)
            COMP_Y:  w_comp_nxt = COMP_CB;
            COMP_CB: w_comp_nxt = COMP_CR;
            default: w_comp_nxt = COMP_Y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_in_fire)
            r_mem[{r_wr_bank, r_wr_idx}] <= {w_cr, w_cb, w_y};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= 2'b00;
            r_wr_bank <= 1'b0;
            r_wr_idx  <= 6'd0;
            r_rd_bank <= 1'b0;
            r_rd_row  <= 3'd0;
            r_rd_comp <= COMP_Y;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_fire)
                r_wr_idx <= r_wr_idx + 6'd1;
            if (w_wr_done)
                r_wr_bank <= !r_wr_bank;
            if (w_out_fire) begin
                r_rd_row <= r_rd_row + 3'd1;
                if (r_rd_row == 3'(BLOCK_DIM - 1))
                    r_rd_comp <= w_comp_nxt;
            end
            if (w_rd_done)
                r_rd_bank <= !r_rd_bank;
        end
    end

    always_comb begin
        w_row = '0;
        for (int c = 0; c < BLOCK_DIM; c++) begin
            case (r_rd_comp)
                COMP_CB: w_row[c*8 +: 8] =
                    r_mem[{r_rd_bank, r_rd_row, 3'(c)}][15:8];
                COMP_CR: w_row[c*8 +: 8] =
                    r_mem[{r_rd_bank, r_rd_row, 3'(c)}][23:16];
                default: w_row[c*8 +: 8] =
                    r_mem[{r_rd_bank, r_rd_row, 3'(c)}][7:0];
            endcase
        end
    end

    assign out_data = out_valid ? w_row : 64'd0;
    assign out_comp = r_rd_comp;
    assign out_row  = r_rd_row;
    assign out_last = out_valid && w_rd_last;

endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// Randomized bench for ycbcr_block_buffer with a block-level reference model.
module tb_ycbcr_block_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_Y = '0;
    logic [31:0] in_Cb = '0;
    logic [31:0] in_Cr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  out_comp;
    logic [2:0]  out_row;
    logic        out_last;

    always #5 clk = ~clk;

    ycbcr_block_buffer #(.SCALE(16), .FIXED_POINT_LENGTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_Y(in_Y), .in_Cb(in_Cb), .in_Cr(in_Cr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_comp(out_comp),
        .out_row(out_row), .out_last(out_last)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  comp;
        logic [2:0]  row;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  blk [0:2][0:63];
    int          blk_cnt = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          mode = 0;
    int          pix_idx = 0;
    int          pix_left = 0;
    int          vprob = 100;
    int          rprob = 100;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Floor-divide rounding, clamp and shift straight from the arithmetic rules.
    function automatic logic [7:0] conv(input logic [31:0] w);
        longint n, q;
        n = longint'($signed(w)) + 64'sd32768;
        q = n / 65536;
        if (n < 0 && q * 65536 != n) q = q - 1;
        if (q < 0) q = 0;
        if (q > 255) q = 255;
        return 8'(q - 128);
    endfunction

    function automatic logic [31:0] gen(input int m, input int idx,
                                        input int c);
        int ip;
        logic [15:0] fr;
        case (m)
            0: return (c == 0) ? 32'h0080_8000 :
                      (c == 1) ? 32'h0080_7FFF : 32'h0000_0000;
            1: return (c == 0) ? 32'h012C_0000 :
                      (c == 1) ? 32'hFFFF_0000 : 32'h00FF_0000;
            2: return 32'((c * 64 + idx) * 65536);
            default: begin
                if ($urandom_range(9) == 0) return $urandom;
                ip = int'($urandom_range(400)) - 72;
                fr = ($urandom_range(3) == 0) ? 16'h8000 : 16'($urandom);
                return 32'(ip * 65536) + {16'h0, fr};
            end
        endcase
    endfunction

    function automatic logic [63:0] spec_row(input int m, input int c,
                                             input int r);
        logic [63:0] d;
        logic [7:0] b;
        d = '0;
        for (int k = 0; k < 8; k++) begin
            case (m)
                0: b = (c == 0) ? 8'h01 : (c == 1) ? 8'h00 : 8'h80;
                1: b = (c == 1) ? 8'h80 : 8'h7F;
                default: b = 8'(c * 64 + r * 8 + k - 128);
            endcase
            d[k*8 +: 8] = b;
        end
        return d;
    endfunction

    task automatic model_push(input logic [31:0] y, input logic [31:0] cb,
                              input logic [31:0] cr);
        beat_t b;
        blk[0][blk_cnt] = conv(y);
        blk[1][blk_cnt] = conv(cb);
        blk[2][blk_cnt] = conv(cr);
        blk_cnt++;
        if (blk_cnt == 64) begin
            for (int c = 0; c < 3; c++)
                for (int r = 0; r < 8; r++) begin
                    for (int k = 0; k < 8; k++)
                        b.data[k*8 +: 8] = blk[c][r*8 + k];
                    b.comp = 2'(c);
                    b.row  = 3'(r);
                    b.last = (c == 2 && r == 7);
                    exp_q.push_back(b);
                end
            blk_cnt = 0;
        end
    endtask

    task automatic tick();
        logic [31:0] y, cb, cr;
        logic ifire, ofire;
        int pend;
        beat_t e;
        @(negedge clk);
        y  = gen(mode, pix_idx % 64, 0);
        cb = gen(mode, pix_idx % 64, 1);
        cr = gen(mode, pix_idx % 64, 2);
        in_Y = y; in_Cb = cb; in_Cr = cr;
        in_valid  = (pix_left > 0) && (int'($urandom_range(99)) < vprob);
        out_ready = (int'($urandom_range(99)) < rprob);
        #1;
        pend = (exp_q.size() + 23) / 24;
        chk("in_ready", in_ready, pend < 2);
        chk("out_valid", out_valid, pend > 0);
        if (prev_stall) chk("hold", out_data, prev_data);
        ifire = in_valid && in_ready;
        ofire = out_valid && out_ready;
        if (ofire) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("data", out_data, e.data);
                chk("tag", {out_last, out_comp, out_row},
                    {e.last, e.comp, e.row});
                if (mode <= 2)
                    chk("directed", out_data,
                        spec_row(mode, int'(e.comp), int'(e.row)));
            end
        end
        if (ifire) begin
            model_push(y, cb, cr);
            pix_idx++;
            pix_left--;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
    endtask

    task automatic check_reset_outputs();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_tags", {out_last, out_comp, out_row}, 0);
        chk("rst_out_data", out_data, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        exp_q.delete();
        blk_cnt = 0;
        prev_stall = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    task automatic run_phase(input int m, input int npix, input int vp,
                             input int rp, input int budget,
                             input string tag);
        int n;
        mode = m; pix_idx = 0; pix_left = npix;
        vprob = vp; rprob = rp;
        n = 0;
        while ((pix_left > 0 || exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, (pix_left > 0 || exp_q.size() > 0), 0);
    endtask

    initial begin
        #2;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        run_phase(0, 64, 100, 100, 500, "round_done");
        run_phase(1, 64, 100, 100, 500, "sat_done");
        run_phase(2, 64, 100, 100, 500, "order_done");

        mode = 3; pix_idx = 0; pix_left = 192;
        vprob = 100; rprob = 0;
        repeat (300) tick();
        chk("bp_accepted", 192 - pix_left, 128);
        chk("bp_in_ready", in_ready, 0);
        run_phase(3, pix_left, 100, 100, 1000, "bp_done");

        run_phase(3, 1280, 50, 50, 20000, "rand_done");

        mode = 3; pix_idx = 0; pix_left = 40;
        vprob = 100; rprob = 100;
        repeat (60) if (pix_left > 0) tick();
        chk("partial_fed", pix_left, 0);
        do_reset();
        run_phase(3, 64, 100, 100, 500, "post_rst_done");

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ycbcr_block_buffer.md
Name: ycbcr_block_buffer

Overview:
Downstream stage of the RGB->YCbCr converter. It accepts per-pixel Y/Cb/Cr fixed-point words and rounds each to 8 bits with saturation. It then level-shifts each sample by -128 and collects 64 pixels (one 8x8 block, row-major) into a ping-pong buffer. Full blocks are emitted as 8-sample rows per component (Y rows 0-7, then Cb, then Cr) to the 2-D DCT stage.

Parameters:
- SCALE, 16, fractional bits of input fixed-point words.
- FIXED_POINT_LENGTH, 32, input word width (two's complement).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  pixel triple valid
- in_ready  output  1  buffer can accept a pixel
- in_Y  input  FIXED_POINT_LENGTH  Y, signed fixed point
- in_Cb  input  FIXED_POINT_LENGTH  Cb, signed fixed point
- in_Cr  input  FIXED_POINT_LENGTH  Cr, signed fixed point
- out_valid  output  1  row beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  64  8 signed 8-bit samples; column 0 in bits [7:0], column 7 in bits [63:56]
- out_comp  output  2  0=Y, 1=Cb, 2=Cr
- out_row  output  3  row index within block
- out_last  output  1  high on the Cr row-7 beat

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: in_ready=1, out_valid=0, out_comp=0, out_row=0, out_last=0, out_data=0. All bank-full flags, pointers and indices are cleared. A partial block in progress at reset is discarded; reset mid-output drops the block.
- Sample conversion (per component, combinational before the write):
  - t = in + 2^(SCALE-1), arithmetic right shift by SCALE (round half up).
  - Clamp t to 0..255.
  - Stored value is s = t - 128, signed 8-bit in range -128..127.
- Storage: two banks, each 64 entries x 24 bits (Y, Cb, Cr). Each bank has a registered full flag.
- Write side:
  - in_ready = !full[wr_bank].
  - A transfer occurs when in_valid && in_ready. Sample goes to bank wr_bank at entry wr_idx; wr_idx increments.
  - On the transfer with wr_idx==63: set full[wr_bank], toggle wr_bank, wr_idx wraps to 0.
- Read side:
  - out_valid = full[rd_bank].
  - out_data is 8 consecutive entries of row out_row, component out_comp, from bank rd_bank. It is held stable while out_valid && !out_ready.
  - A beat transfers when out_valid && out_ready. Sequence: out_row 0..7, then out_comp advances Y->Cb->Cr. That is 24 beats per block.
  - On the beat with comp=2, row=7: clear full[rd_bank], toggle rd_bank, reset comp/row to 0.
- Latency: out_valid rises the cycle after the 64th pixel is accepted, if the read bank is idle.
- Simultaneous events: a write-complete and a read-complete in the same cycle act on different banks; both flag updates take effect.
  - A bank completing read in cycle N may be written from cycle N+1 (in_ready rises N+1).
- Full condition: both banks full -> in_ready=0. Input is stalled with no loss.
- Empty condition: no full bank -> out_valid=0.
- Throughput: 1 pixel/cycle in, 1 row/cycle out. Steady state is limited by 64 write cycles per block vs 24 read cycles per block, so the output side never backs up an unstalled input.

Decomposition:
- Package ycbcr_block_pkg:
  - BLOCK_DIM=8, BLOCK_PIXELS=64, LEVEL_SHIFT=128.
  - COMP_Y=0, COMP_CB=1, COMP_CR=2.
  - ROWS_PER_BLOCK_OUT=24.
- Sub-module ycbcr_round_shift (round, saturate, level shift; purely combinational), instantiated three times.
- Bank control and pointers live in the top module.

Test Plan:
1. Rounding and level shift: Y=0x0080_8000 (128.5), Cb=0x0080_7FFF, Cr=0x0000_0000 for all 64 pixels. Expected Y bytes 0x01, Cb 0x00, Cr 0x80 in every row.
2. Saturation: Y=0x012C_0000 (300.0), Cb=0xFFFF_0000 (-1.0), Cr=0x00FF_0000 (255.0). Expected Y 0x7F, Cb 0x80, Cr 0x7F.
3. Ordering:
   - Stimulus: Y integer = pixel index 0..63; Cb = 64+index; Cr = 128+index.
   - Y row 2 out_data = bytes 16..23 minus 128 (0x90..0x97).
   - 24 beats total, with out_last only on comp=2, row=7.
4. Ping-pong backpressure:
   - Hold out_ready=0 while streaming 3 blocks.
   - in_ready drops after pixel 128 and stays low.
   - After releasing out_ready, blocks 1 and 2 emerge intact, in order, then block 3 is accepted.
5. Random stall: random in_valid and out_ready (50%) over 20 blocks. Scoreboard matches every beat, and out_data is stable during stalls.
6. Reset mid-block: assert rst_n=0 after 40 pixels, then feed a full block. Only the new block is output; out_valid=0 and in_ready=1 during reset.
